// File: rtl/bus1_pkg.sv
// Shared Bus-1 definitions: widths, the C1 command/response codes and a read-command helper.
package bus1_pkg;

    localparam int unsigned BUS1_ADDR_W   = 15;
    localparam int unsigned BUS1_OFFSET_W = 4;
    localparam int unsigned BUS1_DATA_W   = 16;
    localparam int unsigned BUS1_CTR_W    = 3;

    typedef logic [BUS1_CTR_W-1:0] c1_cmd_t;

    localparam c1_cmd_t C1_NOP             = 3'd0;
    localparam c1_cmd_t C1_READ8           = 3'd1;
    localparam c1_cmd_t C1_READ16          = 3'd2;
    localparam c1_cmd_t C1_READ32          = 3'd3;
    localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
    localparam c1_cmd_t C1_WRITE8          = 3'd5;
    localparam c1_cmd_t C1_WRITE16         = 3'd6;
    localparam c1_cmd_t C1_WRITE32         = 3'd7;
    localparam c1_cmd_t C1_RESPONSE        = 3'd7;

    function automatic logic c1_is_read(input c1_cmd_t cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

endpackage

// File: rtl/bus1_tristate_drv.sv
// Registered tristate driver: enable and data flops, bus floats whenever the enable flop is clear.
module bus1_tristate_drv #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_d,
    input  logic [W-1:0] data_d,
    output wire  [W-1:0] bus
);

    logic         en_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign bus = en_q ? data_q : {W{1'bz}};

endmodule

// File: rtl/cache_bus1_slave.sv
// Bus-1 slave front end: decodes the two-beat CPU command, issues one core request,
// and returns the core's answer on D1/C1, owning those buses only while responding.
module cache_bus1_slave
    import bus1_pkg::*;
#(
    parameter int unsigned ADDR1_W  = BUS1_ADDR_W,
    parameter int unsigned OFFSET_W = BUS1_OFFSET_W,
    parameter int unsigned DATA1_W  = BUS1_DATA_W,
    parameter int unsigned CTR1_W   = BUS1_CTR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR1_W-1:0]          a1,
    inout  wire  [DATA1_W-1:0]          d1,
    inout  wire  [CTR1_W-1:0]           c1,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [CTR1_W-1:0]           req_cmd,
    output logic [ADDR1_W+OFFSET_W-1:0] req_addr,
    output logic [2*DATA1_W-1:0]        req_wdata,
    input  logic                        resp_valid,
    input  logic [2*DATA1_W-1:0]        resp_rdata
);

    localparam int unsigned WDATA_W = 2 * DATA1_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR2   = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RESP1   = 3'd4;
    localparam logic [2:0] S_RESP2   = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    localparam logic [CTR1_W-1:0] CMD_NOP     = CTR1_W'(C1_NOP);
    localparam logic [CTR1_W-1:0] CMD_READ8   = CTR1_W'(C1_READ8);
    localparam logic [CTR1_W-1:0] CMD_READ32  = CTR1_W'(C1_READ32);
    localparam logic [CTR1_W-1:0] CMD_INVAL   = CTR1_W'(C1_INVALIDATE_LINE);
    localparam logic [CTR1_W-1:0] CMD_WRITE32 = CTR1_W'(C1_WRITE32);
    localparam logic [CTR1_W-1:0] CMD_RESP    = CTR1_W'(C1_RESPONSE);

    logic [2:0]                  state_q, state_d;
    logic                        req_valid_d;
    logic [CTR1_W-1:0]           req_cmd_d;
    logic [ADDR1_W+OFFSET_W-1:0] req_addr_d;
    logic [WDATA_W-1:0]          req_wdata_d;
    logic [DATA1_W-1:0]          rdata_hi_q, rdata_hi_d;
    logic                        d1_en_d, c1_en_d;
    logic [DATA1_W-1:0]          d1_data_d;
    logic [CTR1_W-1:0]           c1_data_d;
    logic                        cmd_is_read;

    assign cmd_is_read = c1_is_read(c1_cmd_t'(req_cmd));

    // Driver flops load with the next state's bus values so RESP beats appear right after the edge.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid;
        req_cmd_d   = req_cmd;
        req_addr_d  = req_addr;
        req_wdata_d = req_wdata;
        rdata_hi_d  = rdata_hi_q;
        d1_en_d     = 1'b0;
        d1_data_d   = '0;
        c1_en_d     = 1'b0;
        c1_data_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (c1 != CMD_NOP) begin
                    req_cmd_d   = c1;
                    req_addr_d  = {a1, {OFFSET_W{1'b0}}};
                    req_wdata_d = WDATA_W'(d1);
                    if (c1 == CMD_INVAL) begin
                        req_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        state_d     = S_ADDR2;
                    end
                end
            end
            S_ADDR2: begin
                req_addr_d[OFFSET_W-1:0] = a1[OFFSET_W-1:0];
                if (req_cmd == CMD_WRITE32) begin
                    req_wdata_d[WDATA_W-1:DATA1_W] = d1;
                end
                req_valid_d = 1'b1;
                state_d     = S_REQ;
            end
            S_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    rdata_hi_d = resp_rdata[WDATA_W-1:DATA1_W];
                    c1_en_d    = 1'b1;
                    c1_data_d  = CMD_RESP;
                    d1_en_d    = cmd_is_read;
                    d1_data_d  = (req_cmd == CMD_READ8) ? DATA1_W'(resp_rdata[7:0])
                                                        : resp_rdata[DATA1_W-1:0];
                    state_d    = S_RESP1;
                end
            end
            S_RESP1: begin
                if (req_cmd == CMD_READ32) begin
                    c1_en_d   = 1'b1;
                    c1_data_d = CMD_RESP;
                    d1_en_d   = 1'b1;
                    d1_data_d = rdata_hi_q;
                    state_d   = S_RESP2;
                end else begin
                    state_d   = S_RELEASE;
                end
            end
            S_RESP2:   state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_valid  <= 1'b0;
            req_cmd    <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            rdata_hi_q <= '0;
        end else begin
            state_q    <= state_d;
            req_valid  <= req_valid_d;
            req_cmd    <= req_cmd_d;
            req_addr   <= req_addr_d;
            req_wdata  <= req_wdata_d;
            rdata_hi_q <= rdata_hi_d;
        end
    end

    bus1_tristate_drv #(.W(DATA1_W)) u_d1_drv (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (d1_en_d),
        .data_d (d1_data_d),
        .bus    (d1)
    );

    bus1_tristate_drv #(.W(CTR1_W)) u_c1_drv (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_d   (c1_en_d),
        .data_d (c1_data_d),
        .bus    (c1)
    );

endmodule

// File: tb/tb_cache_bus1_slave.sv
// Bench for cache_bus1_slave: directed command table, hand-written corner sequences, random commands.
module tb_cache_bus1_slave;

    localparam logic [15:0] REL_D1 = 16'hFFFF;  // released d1 reads as pulled-up ones
    localparam logic [2:0]  REL_C1 = 3'd0;      // released c1 reads as pulled-down zero (NOP)

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] a1;
    wire  [15:0] d1;
    wire  [2:0]  c1;
    logic [15:0] d1_drv;
    logic        d1_oe;
    logic [2:0]  c1_drv;
    logic        c1_oe;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    assign d1 = d1_oe ? d1_drv : 16'hzzzz;
    assign c1 = c1_oe ? c1_drv : 3'bzzz;
    pullup   (d1);
    pulldown (c1);

    always #5 clk = ~clk;

    cache_bus1_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a1         (a1),
        .d1         (d1),
        .c1         (c1),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [14:0] tagset;
        logic [3:0]  offset;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] rdata;
        int          stall;
        int          delay;
        logic [18:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_beats;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] cmd, input logic [14:0] tag, input logic [3:0] off,
                                 input logic [15:0] lo, input logic [15:0] hi, input logic [31:0] rdata,
                                 input int stall, input int delay, input logic [18:0] ea,
                                 input logic [31:0] ew, input int eb, input logic [15:0] e0,
                                 input logic [15:0] e1);
        vec_t v;
        v.cmd = cmd; v.tagset = tag; v.offset = off; v.lo = lo; v.hi = hi; v.rdata = rdata;
        v.stall = stall; v.delay = delay; v.exp_addr = ea; v.exp_wdata = ew;
        v.exp_beats = eb; v.exp_d0 = e0; v.exp_d1 = e1;
        return v;
    endfunction

    // Reference: what the CPU should see for a command, straight from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   addr = int'(v.tagset) * 16 + ((v.cmd == 3'd4) ? 0 : int'(v.offset));
        r.exp_addr  = 19'(addr);
        r.exp_wdata = (v.cmd == 3'd7) ? (32'(v.hi) * 32'h1_0000 + 32'(v.lo)) : 32'(v.lo);
        r.exp_beats = (v.cmd == 3'd3) ? 2 : 1;
        case (v.cmd)
            3'd1:       r.exp_d0 = 16'(v.rdata % 256);
            3'd2, 3'd3: r.exp_d0 = 16'(v.rdata % 65536);
            default:    r.exp_d0 = REL_D1;
        endcase
        r.exp_d1 = 16'(v.rdata / 65536);
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input bit spurious, input bit stop_in_resp1);
        logic [18:0] addr0;
        logic [31:0] wdata0;
        a1 = v.tagset; d1_drv = v.lo; d1_oe = 1'b1; c1_drv = v.cmd; c1_oe = 1'b1;
        step();
        c1_oe = 1'b0; c1_drv = 3'd0;
        if (v.cmd != 3'd4) begin
            a1 = {11'($urandom), v.offset}; d1_drv = v.hi;
            step();
        end
        d1_oe = 1'b0; d1_drv = 16'($urandom); a1 = 15'($urandom);
        check("req_valid_up", 32'(req_valid), 32'd1);
        check("req_cmd", 32'(req_cmd), 32'(v.cmd));
        check("req_addr", 32'(req_addr), 32'(v.exp_addr));
        check("req_wdata", req_wdata, v.exp_wdata);
        addr0 = req_addr; wdata0 = req_wdata;
        for (int i = 0; i < v.stall; i++) begin
            if (spurious && i == 0) begin
                resp_valid = 1'b1; resp_rdata = 32'h5555_5555;
            end
            a1 = 15'($urandom);
            step();
            resp_valid = 1'b0;
            check("stall_valid", 32'(req_valid), 32'd1);
            check("stall_addr", 32'(req_addr), 32'(addr0));
            check("stall_wdata", req_wdata, wdata0);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("req_valid_down", 32'(req_valid), 32'd0);
        for (int i = 0; i < v.delay; i++) begin
            step();
            check("wait_c1_released", 32'(c1), 32'(REL_C1));
        end
        resp_valid = 1'b1; resp_rdata = v.rdata;
        step();
        resp_valid = 1'b0; resp_rdata = $urandom;
        check("resp1_c1", 32'(c1), 32'd7);
        check("resp1_d1", 32'(d1), 32'(v.exp_d0));
        if (stop_in_resp1) return;
        if (v.exp_beats == 2) begin
            step();
            check("resp2_c1", 32'(c1), 32'd7);
            check("resp2_d1", 32'(d1), 32'(v.exp_d1));
        end
        step();
        check("release_c1", 32'(c1), 32'(REL_C1));
        check("release_d1", 32'(d1), 32'(REL_D1));
        step();
        check("idle_d1", 32'(d1), 32'(REL_D1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        vec_t v;

        tbl[0] = mkv(3'd1, 15'h0010, 4'h5, 16'h0000, 16'h0000, 32'h0000_12AB, 0, 0,
                     19'h00105, 32'h0000_0000, 1, 16'h00AB, 16'h0000);
        tbl[1] = mkv(3'd3, 15'h1234, 4'hA, 16'h1111, 16'h2222, 32'hDEAD_BEEF, 1, 2,
                     19'h1234A, 32'h0000_1111, 2, 16'hBEEF, 16'hDEAD);
        tbl[2] = mkv(3'd7, 15'h0100, 4'h3, 16'h5678, 16'h1234, 32'h0000_0000, 0, 1,
                     19'h01003, 32'h1234_5678, 1, REL_D1, 16'h0000);
        tbl[3] = mkv(3'd4, 15'h7FFF, 4'h9, 16'h4321, 16'h0000, 32'h0BAD_0BAD, 5, 0,
                     19'h7FFF0, 32'h0000_4321, 1, REL_D1, 16'h0000);
        tbl[4] = mkv(3'd5, 15'h0001, 4'h0, 16'h00CC, 16'hAAAA, 32'h1357_9BDF, 0, 0,
                     19'h00010, 32'h0000_00CC, 1, REL_D1, 16'h0000);
        tbl[5] = mkv(3'd2, 15'h2AAA, 4'hF, 16'h0000, 16'h0000, 32'hCAFE_F00D, 0, 3,
                     19'h2AAAF, 32'h0000_0000, 1, 16'hF00D, 16'h0000);
        tbl[6] = mkv(3'd6, 15'h7000, 4'h1, 16'hBEEF, 16'h5555, 32'hFFFF_FFFF, 2, 0,
                     19'h70001, 32'h0000_BEEF, 1, REL_D1, 16'h0000);

        rst_n = 1'b0; a1 = '0; d1_drv = '0; d1_oe = 1'b0; c1_drv = '0; c1_oe = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        repeat (3) step();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_cmd", 32'(req_cmd), 32'd0);
        check("rst_req_addr", 32'(req_addr), 32'd0);
        check("rst_req_wdata", req_wdata, 32'd0);
        check("rst_d1", 32'(d1), 32'(REL_D1));
        check("rst_c1", 32'(c1), 32'(REL_C1));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, 1'b0);

        // Stray resp_valid in IDLE and in REQ must not produce a response.
        resp_valid = 1'b1; resp_rdata = 32'h5555_5555;
        step();
        resp_valid = 1'b0;
        check("spur_idle_c1", 32'(c1), 32'(REL_C1));
        check("spur_idle_valid", 32'(req_valid), 32'd0);
        v = mkv(3'd2, 15'h0ABC, 4'h6, 16'h0000, 16'h0000, 32'h7777_1A2B, 2, 3,
                19'h0ABC6, 32'h0000_0000, 1, 16'h1A2B, 16'h0000);
        run_vec(v, 1'b1, 1'b0);

        // Asynchronous reset while the response beat is on the bus.
        v = model(mkv(3'd1, 15'h0042, 4'h7, 16'h0000, 16'h0000, 32'h0000_00E5, 0, 1,
                      '0, '0, 0, '0, '0));
        run_vec(v, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d1", 32'(d1), 32'(REL_D1));
        check("midrst_c1", 32'(c1), 32'(REL_C1));
        check("midrst_valid", 32'(req_valid), 32'd0);
        check("midrst_addr", 32'(req_addr), 32'd0);
        check("midrst_cmd", 32'(req_cmd), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_vec(v, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v.cmd    = 3'($urandom_range(1, 7));
            v.tagset = 15'($urandom);
            v.offset = 4'($urandom);
            v.lo     = 16'($urandom);
            v.hi     = 16'($urandom);
            v.rdata  = $urandom;
            v.stall  = int'($urandom_range(0, 3));
            v.delay  = int'($urandom_range(0, 3));
            run_vec(model(v), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_bus1_slave.md
# cache_bus1_slave

Bus-1 slave front end of the cache. It sits directly downstream of the CPU model on the A1/D1/C1 bus. It decodes the CPU's two-beat command protocol (tag+set, then offset), assembles one request per command for the cache core, and returns the core's answer to the CPU as a `C1_RESPONSE` transaction. It owns D1/C1 only while responding and releases them to high-Z otherwise.

## Interface

Parameters:
- `ADDR1_W`, default 15: A1 width; carries tag+set in beat 1.
- `OFFSET_W`, default 4: offset bits, carried in A1[OFFSET_W-1:0] in beat 2.
- `DATA1_W`, default 16: D1 width.
- `CTR1_W`, default 3: C1 width.

Ports:
- `clk`, input, 1: single clock. All state changes on rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `a1`, input, ADDR1_W: CPU address bus.
- `d1`, inout, DATA1_W: data bus. Driven only in RESP states, else `'z`.
- `c1`, inout, CTR1_W: command/response bus. Driven only in RESP states, else `'z`.
- `req_valid`, output, 1: request to cache core is valid.
- `req_ready`, input, 1: core accepts the request.
- `req_cmd`, output, CTR1_W: captured C1 command code.
- `req_addr`, output, ADDR1_W+OFFSET_W: {tagset, offset} in bytes.
- `req_wdata`, output, 2*DATA1_W: write data, formatted {hi, lo}.
- `resp_valid`, input, 1: one-cycle pulse; the core's answer is ready.
- `resp_rdata`, input, 2*DATA1_W: read result, right-aligned.

## Operation

- Command codes: `NOP`=0, `READ8`=1, `READ16`=2, `READ32`=3, `INVALIDATE_LINE`=4, `WRITE8`=5, `WRITE16`=6, `WRITE32`=7. Response code: `C1_RESPONSE`=7.
- C1 sampled as 0, Z, or X in IDLE counts as NOP.
- State machine and transitions:
  - IDLE: on a non-NOP c1, capture cmd, a1 as tagset, d1 as wdata lo. Go to ADDR2. For `INVALIDATE_LINE`, set offset to 0 and go straight to REQ.
  - ADDR2: capture a1[OFFSET_W-1:0] as offset. For `WRITE32` only, capture d1 as wdata hi; otherwise wdata hi is 0. Go to REQ.
  - REQ: hold `req_valid`=1 with stable cmd, addr and wdata until `req_valid && req_ready`. Go to WAIT.
  - WAIT: on `resp_valid`, latch `resp_rdata` and go to RESP1.
  - RESP1: drive c1=`C1_RESPONSE`. d1 carries:
    - rdata[7:0] zero-extended for `READ8`,
    - rdata[15:0] for `READ16`/`READ32`,
    - `'z` for writes and invalidate.
    For `READ32` go to RESP2, else to RELEASE.
  - RESP2: drive c1=`C1_RESPONSE` and d1=rdata[31:16]. Go to RELEASE.
  - RELEASE: d1 and c1 back to `'z`. Go to IDLE. This is the one-cycle turnaround before the CPU drives again.
- Bus values are ignored in every state except IDLE and ADDR2, because the CPU is not the bus owner then.
- `resp_valid` outside WAIT is ignored.
- Only one command is outstanding at a time; there is no queueing.

## Timing

- Reset values (asynchronous on `rst_n`=0, mid-operation included):
  - state IDLE, `req_valid`=0, `req_cmd`=0, `req_addr`=0, `req_wdata`=0,
  - d1 and c1 released to `'z`.
  - Any in-flight command is dropped.
- Let the CPU command be sampled at edge E0 with beat 2 at E1:
  - `req_valid` rises after E1.
  - With `req_ready` tied high, the handshake completes at E2.
- If `resp_valid` is sampled at edge Ek, c1=`C1_RESPONSE` is visible after Ek and held for one cycle; `READ32` holds it for two cycles.
- Release occurs after the last RESP edge.
- Minimum command-to-response with a zero-latency core is 3 cycles from E0.
- A `req_ready` stall holds REQ indefinitely with all req_* stable.

## Structure

- Shared package `bus1_pkg`:
  - typedef `c1_cmd_t` (CTR1_W bits),
  - constants `C1_NOP` … `C1_WRITE32` and `C1_RESPONSE`,
  - bus width constants, which the CPU model also uses.
- One natural sub-module, `bus1_tristate_drv`: holds the drive-enable register plus data register, and maps a disabled output to `'z`. Instantiated for d1 and for c1.

## Test plan

- Reset mid-op: assert `rst_n`=0 during RESP1 -> d1 and c1 read `'z`, `req_valid`=0; a new `READ8` after reset completes normally.
- `READ8`, core returns 0x0000_12AB:
  - stimulus: tagset 0x0010, offset 0x5.
  - required: `req_addr` = 0x00105, `req_cmd`=1, single RESP beat with d1=0x00AB.
- `READ32`, core returns 0xDEAD_BEEF: two RESP beats, d1 = 0xBEEF then 0xDEAD, then `'z`.
- `WRITE32` of 0x1234_5678 (d1 = 0x5678 on beat 1, 0x1234 on beat 2):
  - required: `req_wdata` = 0x1234_5678, `req_cmd`=7.
  - then one RESP beat with d1=`'z`.
- `INVALIDATE_LINE`, tagset 0x7FFF, `req_ready` low for 5 cycles:
  - required: `req_addr`=0x7FFF0 with `req_valid` stable for 5 cycles.
  - then handshake, then a one-beat response.
- `READ16` with `resp_valid` pulses injected in IDLE and REQ -> both are ignored; the response comes only from the pulse in WAIT.
